// File: rtl/usr_frame_rx.sv
// usr_frame_rx: serial start/data/parity/stop frame receiver with one-entry valid/ready holding register
module usr_frame_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             bit_en,
    input  logic             pready,
    output logic [WIDTH-1:0] pout,
    output logic             pvalid,
    output logic             perr,
    output logic             ferr,
    output logic             ovr,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             pbit;
    logic             done;
    logic             free;

    assign done = bit_en && state == STOP;
    assign free = !pvalid || pready;

    // Next-state: only strobed cycles advance the frame.
    always_comb begin
        state_n = state;
        if (bit_en)
            case (state)
                IDLE:      state_n = sin ? IDLE : DATA;
                DATA:      state_n = (cnt == LAST) ? PARITY : DATA;
                PARITY:    state_n = STOP;
                STOP:      state_n = sin ? IDLE : WAIT_HIGH;
                WAIT_HIGH: state_n = sin ? IDLE : WAIT_HIGH;
                default:   state_n = IDLE;
            endcase
    end

    // State register, registered busy, and the deserializer datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            shreg <= '0;
            cnt   <= '0;
            pbit  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= state_n != IDLE;
            if (bit_en && state == IDLE && !sin)
                cnt <= '0;
            if (bit_en && state == DATA) begin
                shreg <= {shreg[WIDTH-2:0], sin};
                cnt   <= cnt + CW'(1);
            end
            if (bit_en && state == PARITY)
                pbit <= sin;
        end
    end

    // Holding register: load on completion when free, drop with ovr when occupied, clear on consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pout   <= '0;
            pvalid <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            ovr <= done && !free;
            if (done && free) begin
                pout   <= shreg;
                perr   <= ^{shreg, pbit};
                ferr   <= !sin;
                pvalid <= 1'b1;
            end else if (pvalid && pready) begin
                pvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_usr_frame_rx.sv
// tb_usr_frame_rx: directed frame stimulus with hand-computed expectations for usr_frame_rx
module tb_usr_frame_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b1;
    logic       bit_en = 1'b0;
    logic       pready = 1'b1;
    logic [3:0] pout;
    logic       pvalid, perr, ferr, ovr, busy;
    int         n_chk = 0;
    int         n_pass = 0;
    logic       ovr_seen = 1'b0;

    usr_frame_rx #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .sin(sin), .bit_en(bit_en), .pready(pready),
        .pout(pout), .pvalid(pvalid), .perr(perr), .ferr(ferr), .ovr(ovr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic strobe(input logic b);
        sin = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        sin = 1'b1;
        ovr_seen = ovr_seen | ovr;
    endtask

    task automatic frame(input logic [3:0] d, input logic p, input logic s);
        strobe(1'b0);
        for (int i = 3; i >= 0; i--) strobe(d[i]);
        strobe(p);
        strobe(s);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_pout", 32'(pout), 0);
        chk("rst_pvalid", 32'(pvalid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovr", 32'(ovr), 0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        frame(4'b1011, 1'b1, 1'b1);
        chk("t1_pout", 32'(pout), 32'hb);
        chk("t1_pvalid", 32'(pvalid), 1);
        chk("t1_perr", 32'(perr), 0);
        chk("t1_ferr", 32'(ferr), 0);
        chk("t1_busy", 32'(busy), 0);
        idle_cycle();
        chk("t1_consumed", 32'(pvalid), 0);
        chk("t1_pout_kept", 32'(pout), 32'hb);

        frame(4'b1011, 1'b0, 1'b1);
        chk("t2_pout", 32'(pout), 32'hb);
        chk("t2_perr", 32'(perr), 1);
        chk("t2_ferr", 32'(ferr), 0);
        idle_cycle();

        frame(4'b0011, 1'b0, 1'b0);
        chk("t3_pout", 32'(pout), 32'h3);
        chk("t3_ferr", 32'(ferr), 1);
        chk("t3_perr", 32'(perr), 0);
        chk("t3_busy_wait", 32'(busy), 1);
        strobe(1'b0);
        strobe(1'b0);
        chk("t3_busy_ignored", 32'(busy), 1);
        chk("t3_no_frame", 32'(pvalid), 0);
        strobe(1'b1);
        chk("t3_back_idle", 32'(busy), 0);
        frame(4'b0110, 1'b0, 1'b1);
        chk("t3_next_pout", 32'(pout), 32'h6);
        chk("t3_next_pvalid", 32'(pvalid), 1);
        chk("t3_next_ferr", 32'(ferr), 0);
        chk("t3_next_perr", 32'(perr), 0);
        idle_cycle();

        pready = 1'b0;
        frame(4'b1011, 1'b1, 1'b1);
        chk("t4_first_pvalid", 32'(pvalid), 1);
        chk("t4_first_ovr", 32'(ovr), 0);
        frame(4'b0100, 1'b1, 1'b1);
        chk("t4_ovr", 32'(ovr), 1);
        chk("t4_pout_kept", 32'(pout), 32'hb);
        chk("t4_pvalid_kept", 32'(pvalid), 1);
        idle_cycle();
        chk("t4_ovr_pulse", 32'(ovr), 0);
        pready = 1'b1;
        idle_cycle();
        chk("t4_drain", 32'(pvalid), 0);

        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b1);
        chk("t5_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        #2;
        chk("t5_rst_pout", 32'(pout), 0);
        chk("t5_rst_pvalid", 32'(pvalid), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_flags", 32'({perr, ferr, ovr}), 0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();
        frame(4'b1110, 1'b1, 1'b1);
        chk("t5_pout", 32'(pout), 32'he);
        chk("t5_pvalid", 32'(pvalid), 1);
        chk("t5_flags", 32'({perr, ferr}), 0);
        idle_cycle();

        ovr_seen = 1'b0;
        frame(4'b0001, 1'b1, 1'b1);
        chk("t6_a_pout", 32'(pout), 32'h1);
        chk("t6_a_pvalid", 32'(pvalid), 1);
        frame(4'b1000, 1'b1, 1'b1);
        chk("t6_b_pout", 32'(pout), 32'h8);
        chk("t6_b_pvalid", 32'(pvalid), 1);
        frame(4'b1111, 1'b0, 1'b1);
        chk("t6_c_pout", 32'(pout), 32'hf);
        chk("t6_c_pvalid", 32'(pvalid), 1);
        chk("t6_c_perr", 32'(perr), 0);
        idle_cycle();
        chk("t6_c_consumed", 32'(pvalid), 0);
        chk("t6_no_ovr", 32'(ovr_seen), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
